// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter generator
//   pc_sel_e   : next-PC source, listed in falling priority order
//   TRAP_SHIFT : left shift applied to trapvect8 to form the trap target
package pc_pkg;
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_TRAP,
        SEL_CALL,
        SEL_RET,
        SEL_LOAD,
        SEL_INC
    } pc_sel_e;

    localparam int TRAP_SHIFT = 1;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack that overwrites its oldest entry when full
//   clock_50 : clock, rising edge
//   reset_n  : asynchronous active-low reset, empties the stack
//   push_i   : write data_i as the new top entry
//   pop_i    : discard the top entry (ignored when empty)
//   data_i   : return address to push
//   top_o    : current top entry (undefined when empty)
//   count_o  : number of valid entries, 0..DEPTH
//   full_o   : count_o == DEPTH
//   empty_o  : count_o == 0
module pc_ras #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clock_50,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         top_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d, top_ptr;
    logic [AW:0]      cnt_q, cnt_d;

    // ptr_q addresses the next free slot; the pointer wraps, so a push onto a
    // full stack lands on the oldest entry
    assign top_ptr = ptr_q - PTR_ONE;
    assign top_o   = mem_q[top_ptr];
    assign count_o = cnt_q;
    assign full_o  = cnt_q == CNT_FULL;
    assign empty_o = cnt_q == '0;

    always_comb begin
        ptr_d = push_i ? ptr_q + PTR_ONE : (pop_i && !empty_o) ? top_ptr : ptr_q;
        cnt_d = push_i ? (full_o ? cnt_q : cnt_q + CNT_ONE) : (pop_i && !empty_o) ? cnt_q - CNT_ONE : cnt_q;
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock_50) begin
        if (push_i)
            mem_q[ptr_q] <= data_i;
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with trap, load, call/return and stall
//   clock_50      : clock, rising edge
//   reset_n       : asynchronous active-low reset
//   stall         : hold PC and stack, ignore every other request
//   load          : jump to load_addr (bit 0 cleared)
//   load_addr     : jump/call target, fallback target for a return on empty stack
//   trap          : jump to trap_vec << 1
//   trap_vec      : LC-3b trapvect8
//   call          : push out+INC and jump to load_addr
//   ret           : pop return address into PC
//   out           : current PC, registered
//   ras_count     : valid stack entries
//   ras_overflow  : one-cycle pulse, push onto a full stack
//   ras_underflow : one-cycle pulse, pop from an empty stack
// Build option: define PC_GEN_RAS_EN to include the return-address stack;
// without it call and ret behave as load and the stack outputs read 0.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               INC          = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               DEPTH        = 8
) (
    input  logic                   clock_50,
    input  logic                   reset_n,
    input  logic                   stall,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_addr,
    input  logic                   trap,
    input  logic [7:0]             trap_vec,
    input  logic                   call,
    input  logic                   ret,
    output logic [WIDTH-1:0]       out,
    output logic [$clog2(DEPTH):0] ras_count,
    output logic                   ras_overflow,
    output logic                   ras_underflow
);
    pc_sel_e          sel;
    logic [WIDTH-1:0] out_q, pc_d, seq, align, trap_tgt, ret_tgt;
    logic             ovf_d, unf_d, ovf_q, unf_q;

    assign seq      = out_q + WIDTH'(INC);
    assign align    = {load_addr[WIDTH-1:1], 1'b0};
    assign trap_tgt = WIDTH'(trap_vec) << TRAP_SHIFT;

    always_comb begin
        sel = stall ? SEL_HOLD : trap ? SEL_TRAP : call ? SEL_CALL : ret ? SEL_RET : load ? SEL_LOAD : SEL_INC;
        pc_d = sel == SEL_HOLD ? out_q :
               sel == SEL_TRAP ? trap_tgt :
               sel == SEL_RET  ? ret_tgt :
               sel == SEL_INC  ? seq : align;
    end

`ifdef PC_GEN_RAS_EN
    logic [WIDTH-1:0] ras_top;
    logic             ras_full, ras_empty, ras_push, ras_pop;

    assign ras_push = sel == SEL_CALL;
    assign ras_pop  = sel == SEL_RET && !ras_empty;
    // a return with nothing stacked falls back to the supplied load_addr
    assign ret_tgt  = ras_empty ? align : ras_top;
    assign ovf_d    = ras_push && ras_full;
    assign unf_d    = sel == SEL_RET && ras_empty;

    pc_ras #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ras (
        .clock_50(clock_50),
        .reset_n (reset_n),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (seq),
        .top_o   (ras_top),
        .count_o (ras_count),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );
`else
    assign ret_tgt   = align;
    assign ovf_d     = 1'b0;
    assign unf_d     = 1'b0;
    assign ras_count = '0;
`endif

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= RESET_VECTOR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out           = out_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen against a behavioural model
module tb_pc_gen;
    typedef struct {
        string       tag;
        logic [15:0] pc;
        int          cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, stall, load, trap, call, ret;
    logic [15:0] load_addr;
    logic [7:0]  trap_vec;
    logic [15:0] out;
    logic [3:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];

    always #5 clk = ~clk;

    pc_gen dut (
        .clock_50     (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .load         (load),
        .load_addr    (load_addr),
        .trap         (trap),
        .trap_vec     (trap_vec),
        .call         (call),
        .ret          (ret),
        .out          (out),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic s, input logic tr, input logic c,
                        input logic r, input logic l, input logic [15:0] a, input logic [7:0] v);
        exp_t        e;
        exp_t        g;
        logic [15:0] al;
        al = a & 16'hFFFE;
        stall = s; trap = tr; call = c; ret = r; load = l; load_addr = a; trap_vec = v;
        e.tag = tag; e.ovf = 1'b0; e.unf = 1'b0;
        if (s) begin
        end else if (tr) begin
            m_pc = {7'd0, v, 1'b0};
        end else if (c) begin
`ifdef PC_GEN_RAS_EN
            m_stk.push_back(m_pc + 16'd2);
            if (m_stk.size() > 8) begin
                void'(m_stk.pop_front());
                e.ovf = 1'b1;
            end
`endif
            m_pc = al;
        end else if (r) begin
`ifdef PC_GEN_RAS_EN
            if (m_stk.size() == 0) begin
                e.unf = 1'b1;
                m_pc = al;
            end else begin
                m_pc = m_stk.pop_back();
            end
`else
            m_pc = al;
`endif
        end else if (l) begin
            m_pc = al;
        end else begin
            m_pc = m_pc + 16'd2;
        end
        e.pc = m_pc;
        e.cnt = m_stk.size();
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({g.tag, ".out"}, 32'(out), 32'(g.pc));
        chk({g.tag, ".cnt"}, 32'(ras_count), 32'(g.cnt));
        chk({g.tag, ".ovf"}, 32'(ras_overflow), 32'(g.ovf));
        chk({g.tag, ".unf"}, 32'(ras_underflow), 32'(g.unf));
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; load = 1'b0; trap = 1'b0; call = 1'b0; ret = 1'b0;
        load_addr = '0; trap_vec = '0;
        #3;
        chk("rst.out", 32'(out), 32'h0);
        chk("rst.cnt", 32'(ras_count), 32'h0);
        chk("rst.ovf", 32'(ras_overflow), 32'h0);
        chk("rst.unf", 32'(ras_underflow), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_pc = 16'h0000;
        for (int i = 0; i < 4; i++) step($sformatf("inc%0d", i), 0, 0, 0, 0, 0, 16'h0, 8'h0);

        step("ld_fffe", 0, 0, 0, 0, 1, 16'hFFFF, 8'h0);
        step("wrap", 0, 0, 0, 0, 0, 16'h0, 8'h0);

        step("ld_3000", 0, 0, 0, 0, 1, 16'h3000, 8'h0);
        step("call_4001", 0, 0, 1, 0, 0, 16'h4001, 8'h0);
        step("inc_in_call", 0, 0, 0, 0, 0, 16'h0, 8'h0);
        step("ret_3002", 0, 0, 0, 1, 0, 16'h0100, 8'h0);

        step("trap_prio", 0, 1, 1, 0, 1, 16'h5555, 8'h25);
        step("stall_prio", 1, 1, 1, 1, 1, 16'h6666, 8'h77);
        step("call_vs_ret", 0, 0, 1, 1, 1, 16'h2223, 8'h0);
        step("ret_vs_load", 0, 0, 0, 1, 1, 16'h0800, 8'h0);
        step("ret_empty", 0, 0, 0, 1, 0, 16'h0A01, 8'h0);

        for (int i = 0; i < 9; i++)
            step($sformatf("call%0d", i), 0, 0, 1, 0, 0, 16'h1001 + 16'(i * 256), 8'h0);
        step("stall_full", 1, 0, 1, 0, 0, 16'h7000, 8'h0);
        for (int i = 0; i < 8; i++)
            step($sformatf("ret%0d", i), 0, 0, 0, 1, 0, 16'h0, 8'h0);
        step("ret_under", 0, 0, 0, 1, 0, 16'h1234, 8'h0);
        step("after_under", 0, 0, 0, 0, 0, 16'h0, 8'h0);

        step("pre_rst_call", 0, 0, 1, 0, 0, 16'h2000, 8'h0);
        call = 1'b1; load_addr = 16'h7000;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst.out", 32'(out), 32'h0);
        chk("arst.cnt", 32'(ras_count), 32'h0);
        chk("arst.ovf", 32'(ras_overflow), 32'h0);
        chk("arst.unf", 32'(ras_underflow), 32'h0);
        @(posedge clk);
        #1;
        chk("arst_hold.out", 32'(out), 32'h0);
        call = 1'b0;
        #1;
        reset_n = 1'b1;
        m_pc = 16'h0000;
        m_stk.delete();
        step("post_rst_inc", 0, 0, 0, 0, 0, 16'h0, 8'h0);
        step("post_rst_ret", 0, 0, 0, 1, 0, 16'h0500, 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
